// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file slave.
// The FSM state encoding and the ACK/NACK bus levels live here.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_slv_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA conditioning: 2-flop synchroniser, FILT_LEN-sample glitch filter,
// and single-cycle SCL edge / START / STOP strobes derived from the filtered levels.
module i2c_bus_cond #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0]          scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [FILT_LEN-2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic [FILT_LEN-1:0] scl_win, sda_win;
  logic                scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic                scl_prev_q, sda_prev_q;

  // The newest synchronised sample plus FILT_LEN-1 older ones form the window (FILT_LEN >= 2).
  assign scl_win = {scl_hist_q, scl_sync_q[1]};
  assign sda_win = {sda_hist_q, sda_sync_q[1]};

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_hist_d = scl_win[FILT_LEN-2:0];
    sda_hist_d = sda_win[FILT_LEN-2:0];
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    if (&scl_win)       scl_f_d = 1'b1;
    else if (~|scl_win) scl_f_d = 1'b0;
    if (&sda_win)       sda_f_d = 1'b1;
    else if (~|sda_win) sda_f_d = 1'b0;
  end

  // Idle bus is high, so everything resets to 1 and no edge fires out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  assign sda_f     = sda_f_q;
  assign scl_rise  =  scl_f_q & ~scl_prev_q;
  assign scl_fall  = ~scl_f_q &  scl_prev_q;
  assign start_det =  scl_f_q &  scl_prev_q &  sda_prev_q & ~sda_f_q;
  assign stop_det  =  scl_f_q &  scl_prev_q & ~sda_prev_q &  sda_f_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Oversampled I2C slave with a byte-wide register file: address match, pointer
// write, burst write/read with auto-incrementing pointer. Never stretches SCL.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         NUM_REGS = 16,
  parameter int         FILT_LEN = 3
) (
  input  logic                        wb_clk_i,
  input  logic                        arst_i,
  input  logic                        scl_pad_i,
  input  logic                        sda_pad_i,
  output logic                        scl_pad_o,
  output logic                        scl_padoen_o,
  output logic                        sda_pad_o,
  output logic                        sda_padoen_o,
  input  logic [$clog2(NUM_REGS)-1:0] loc_rd_addr,
  output logic [7:0]                  loc_rd_data,
  output logic                        wr_evt,
  output logic [$clog2(NUM_REGS)-1:0] wr_evt_addr,
  output logic [7:0]                  wr_evt_data,
  output logic                        busy
);

  localparam int IDXW = $clog2(NUM_REGS);

  logic sda_f, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_cond #(.FILT_LEN(FILT_LEN)) u_bus_cond (
    .clk       (wb_clk_i),
    .rst       (arst_i),
    .scl_i     (scl_pad_i),
    .sda_i     (sda_pad_i),
    .sda_f     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_slv_state_e  state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            sda_oen_q, sda_oen_d;
  logic            busy_q, busy_d;
  logic [7:0]      regs_q [NUM_REGS];
  logic [7:0]      regs_d [NUM_REGS];

  logic [7:0] byte_in;
  logic       rx_bit, byte_done, ack_edge;

  assign byte_in   = {shift_q[6:0], sda_f};
  assign rx_bit    = scl_rise && (bit_cnt_q < 4'd8);
  assign byte_done = rx_bit && (bit_cnt_q == 4'd7);
  assign ack_edge  = scl_fall && (bit_cnt_q == 4'd8);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oen_d = sda_oen_q;
    busy_d    = busy_q;
    regs_d    = regs_q;
    wr_evt    = 1'b0;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oen_d = 1'b1;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oen_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (rx_bit) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (ack_edge) begin
            bit_cnt_d = 4'd0;
            if (shift_q[7:1] == SLV_ADDR) begin
              state_d   = ST_ADDR_ACK;
              sda_oen_d = I2C_ACK;
            end else begin
              state_d   = ST_WAIT_STOP;
            end
          end
        end
        ST_PTR: begin
          if (rx_bit) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (byte_done) ptr_d = byte_in[IDXW-1:0];
          end else if (ack_edge) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_PTR_ACK;
            sda_oen_d = I2C_ACK;
          end
        end
        ST_WDATA: begin
          if (rx_bit) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (byte_done) begin
              regs_d[ptr_q] = byte_in;
              wr_evt        = 1'b1;
              ptr_d         = ptr_q + 1'b1;
            end
          end else if (ack_edge) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_WDATA_ACK;
            sda_oen_d = I2C_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d   = ST_RDATA;
              shift_d   = regs_q[ptr_q];
              sda_oen_d = regs_q[ptr_q][7];
            end else begin
              state_d   = ST_PTR;
              sda_oen_d = 1'b1;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d   = ST_WDATA;
            sda_oen_d = 1'b1;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (ack_edge) begin
            state_d   = ST_RDATA_ACK;
            bit_cnt_d = 4'd0;
            sda_oen_d = 1'b1;
            ptr_d     = ptr_q + 1'b1;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oen_d = shift_q[6];
          end
        end
        ST_RDATA_ACK: begin
          // Entered on a falling edge, so the next fall always follows the ACK sample.
          if (scl_rise && sda_f == I2C_NACK) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall) begin
            state_d   = ST_RDATA;
            bit_cnt_d = 4'd0;
            shift_d   = regs_q[ptr_q];
            sda_oen_d = regs_q[ptr_q][7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      sda_oen_q <= 1'b1;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oen_q <= sda_oen_d;
      busy_q    <= busy_d;
      regs_q    <= regs_d;
    end
  end

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oen_q;
  assign busy         = busy_q;
  assign loc_rd_data  = regs_q[loc_rd_addr];
  assign wr_evt_addr  = ptr_q;
  assign wr_evt_data  = byte_in;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, open-drain bus model and a
// behavioural register-file/pointer model; directed scenarios plus random transactions.
module tb_i2c_slave_regfile;

  localparam int NUM_REGS = 16;
  localparam int TQ       = 8;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_line, sda_line;
  logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic [3:0] loc_rd_addr = 4'd0;
  logic [7:0] loc_rd_data;
  logic       wr_evt;
  logic [3:0] wr_evt_addr;
  logic [7:0] wr_evt_data;
  logic       busy;

  assign scl_line = scl_m & (scl_padoen_o | scl_pad_o);
  assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_slave_regfile #(.SLV_ADDR(7'h50), .NUM_REGS(NUM_REGS), .FILT_LEN(3)) dut (
    .wb_clk_i     (clk),
    .arst_i       (arst),
    .scl_pad_i    (scl_line),
    .sda_pad_i    (sda_line),
    .scl_pad_o    (scl_pad_o),
    .scl_padoen_o (scl_padoen_o),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .loc_rd_addr  (loc_rd_addr),
    .loc_rd_data  (loc_rd_data),
    .wr_evt       (wr_evt),
    .wr_evt_addr  (wr_evt_addr),
    .wr_evt_data  (wr_evt_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  m_regs [NUM_REGS];
  int          m_ptr = 0;
  logic [7:0]  wq[$];
  logic [11:0] exp_evt[$];
  logic [11:0] got_evt[$];

  int   sda_viol = 0;
  int   pulse_viol = 0;
  logic prev_scl = 1'b1;
  logic prev_oen = 1'b1;
  logic prev_evt = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Bus observers: slave SDA must hold while SCL is high; wr_evt is a single-cycle strobe.
  always @(negedge clk) begin
    if (!arst && scl_m && prev_scl && sda_padoen_o != prev_oen) sda_viol <= sda_viol + 1;
    if (wr_evt && prev_evt) pulse_viol <= pulse_viol + 1;
    if (wr_evt) got_evt.push_back({wr_evt_addr, wr_evt_data});
    prev_scl <= scl_m;
    prev_oen <= sda_padoen_o;
    prev_evt <= wr_evt;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic o, output logic i);
    tick(TQ); sda_m = o;
    tick(TQ); scl_m = 1'b1;
    tick(TQ); i = sda_line;
    tick(TQ); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; tick(2 * TQ); scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    tick(TQ); sda_m = 1'b1;
    tick(TQ); scl_m = 1'b1;
    tick(TQ); sda_m = 1'b0;
    tick(TQ); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(TQ); sda_m = 1'b0;
    tick(TQ); scl_m = 1'b1;
    tick(TQ); sda_m = 1'b1;
    tick(2 * TQ);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, d);
      b[i] = d;
    end
    bit_xfer(nack, d);
  endtask

  task automatic check_evts();
    check_val("wr_evt_cnt", 32'(got_evt.size()), 32'(exp_evt.size()));
    for (int i = 0; i < exp_evt.size() && i < got_evt.size(); i++)
      check_val("wr_evt_ad", 32'(got_evt[i]), 32'(exp_evt[i]));
    got_evt.delete();
    exp_evt.delete();
  endtask

  task automatic compare_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      loc_rd_addr = 4'(i);
      tick(1);
      check_val(tag, 32'(loc_rd_data), 32'(m_regs[i]));
    end
  endtask

  task automatic write_txn(input logic [7:0] p);
    logic ack;
    i2c_start();
    send_byte(8'hA0, ack); check_val("w_addr_ack", 32'(ack), 32'(0));
    send_byte(p, ack);     check_val("w_ptr_ack", 32'(ack), 32'(0));
    m_ptr = int'(p) % NUM_REGS;
    foreach (wq[i]) begin
      send_byte(wq[i], ack); check_val("w_data_ack", 32'(ack), 32'(0));
      m_regs[m_ptr] = wq[i];
      exp_evt.push_back({4'(m_ptr), wq[i]});
      m_ptr = (m_ptr + 1) % NUM_REGS;
    end
    i2c_stop();
    check_evts();
  endtask

  task automatic read_txn(input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'hA0, ack); check_val("r_waddr_ack", 32'(ack), 32'(0));
      send_byte(p, ack);     check_val("r_ptr_ack", 32'(ack), 32'(0));
      m_ptr = int'(p) % NUM_REGS;
      i2c_rstart();
    end
    send_byte(8'hA1, ack); check_val("r_addr_ack", 32'(ack), 32'(0));
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      check_val("r_data", 32'(b), 32'(m_regs[m_ptr]));
      m_ptr = (m_ptr + 1) % NUM_REGS;
    end
    tick(4);
    check_val("r_release", 32'(sda_padoen_o), 32'(1));
    i2c_stop();
    tick(2);
    check_val("r_busy_end", 32'(busy), 32'(0));
  endtask

  initial begin
    logic ack;
    logic d;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    tick(3);
    check_val("rst_oen", 32'(sda_padoen_o), 32'(1));
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_wr_evt", 32'(wr_evt), 32'(0));
    arst = 1'b0;
    tick(10);
    compare_regs("rst_regs");

    // Burst write of two bytes at pointer 3
    wq = '{8'hA5, 8'h5A};
    write_txn(8'h03);
    compare_regs("t1_regs");

    // Random read of the same two bytes
    read_txn(1'b1, 8'h03, 2);

    // Wrong address: never acknowledged
    i2c_start();
    send_byte(8'hA2, ack); check_val("t3_nack", 32'(ack), 32'(1));
    check_val("t3_busy", 32'(busy), 32'(1));
    send_byte(8'h77, ack); check_val("t3_nack2", 32'(ack), 32'(1));
    i2c_stop();
    tick(2);
    check_val("t3_busy_end", 32'(busy), 32'(0));
    check_evts();

    // Pointer wrap and ignored pointer upper bits
    wq = '{8'h11, 8'h22};
    write_txn(8'h0F);
    wq = '{8'h33};
    write_txn(8'h13);
    compare_regs("t4_regs");

    // STOP after four data bits: byte discarded, pointer still from the pointer byte
    i2c_start();
    send_byte(8'hA0, ack); check_val("t5_addr_ack", 32'(ack), 32'(0));
    send_byte(8'h07, ack); check_val("t5_ptr_ack", 32'(ack), 32'(0));
    m_ptr = 7;
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom_range(0, 1)), d);
    i2c_stop();
    tick(2);
    check_val("t5_busy", 32'(busy), 32'(0));
    check_evts();
    compare_regs("t5_regs");
    read_txn(1'b0, 8'h00, 2);

    // Random traffic against the model
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) wq.push_back(8'($urandom));
        write_txn(8'($urandom));
      end else begin
        read_txn(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(1, 4)));
      end
    end
    compare_regs("rnd_regs");

    // Asynchronous reset while the slave drives a 0 data bit
    wq = '{8'h3C};
    write_txn(8'h05);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    i2c_rstart();
    send_byte(8'hA1, ack); check_val("t6_addr_ack", 32'(ack), 32'(0));
    tick(TQ + 2);
    check_val("t6_drive", 32'(sda_padoen_o), 32'(0));
    arst = 1'b1;
    #1;
    check_val("t6_oen", 32'(sda_padoen_o), 32'(1));
    check_val("t6_busy", 32'(busy), 32'(0));
    tick(2);
    arst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    got_evt.delete();
    compare_regs("t6_regs");
    sda_m = 1'b1;
    i2c_stop();
    wq = '{8'hC3, 8'h96};
    write_txn(8'h0E);
    read_txn(1'b1, 8'h0E, 2);

    check_val("sda_stable", 32'(sda_viol), 32'(0));
    check_val("evt_pulse", 32'(pulse_viol), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
